main_memory_responder: RTL
==========================

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of backing-store words; power of two.
REQ-004 SHALL have parameter LATENCY, default 4, cycles from request acceptance to response; legal range 1..15.
REQ-005 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port mem_addr, input, ADDR_WIDTH, byte address from the cache.
REQ-008 SHALL have port mem_data_out, input, DATA_WIDTH, write data from the cache.
REQ-009 SHALL have port mem_read, input, 1, read request level.
REQ-010 SHALL have port mem_write, input, 1, write request level.
REQ-011 SHALL have port mem_data_in, output, DATA_WIDTH, read data to the cache.
REQ-012 SHALL have port mem_ready, output, 1, one-cycle response strobe.
REQ-013 SHALL have port mem_hit, output, 1, address in range; qualified by mem_ready.
REQ-014 SHALL have port busy, output, 1, high when the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP, HOLDOFF.
REQ-016 IDLE: when mem_read or mem_write is high, SHALL latch addr, wdata, and op (write if mem_write), load the counter with LATENCY-1, and go to WAIT (or straight to RESP when LATENCY=1).
REQ-017 SHALL give mem_write priority when mem_read and mem_write are both high; the request is a write only.
REQ-018 WAIT: SHALL decrement the counter each cycle and go to RESP when the counter is 0; request inputs are ignored.
REQ-019 SHALL compute word index = latched addr >> log2(DATA_WIDTH/8); byte-offset bits are ignored.
REQ-020 SHALL define in-range as upper index bits above log2(MEM_DEPTH) all zero.
REQ-021 RESP: SHALL assert mem_ready for exactly one cycle, with mem_hit = in-range.
REQ-022 RESP read, in range: SHALL drive mem_data_in with the stored word in the same cycle as mem_ready.
REQ-023 RESP read, out of range: SHALL drive mem_data_in = 0 and mem_hit = 0.
REQ-024 RESP write, in range: SHALL commit the latched wdata to the array on the RESP clock edge.
REQ-025 RESP write, out of range: SHALL discard the write; mem_hit = 0 and mem_data_in = 0.
REQ-026 RESP SHALL always go to HOLDOFF.
REQ-027 HOLDOFF: SHALL ignore all requests for one cycle, then go to IDLE.
  - Purpose: absorb a request level the cache still holds after mem_ready.
  - Consequence: back-to-back request spacing is at least LATENCY+2 cycles.
REQ-028 SHALL hold mem_data_in at its last RESP value outside RESP.
REQ-029 Latency SHALL be exactly LATENCY cycles from the accepting edge to mem_ready high.
  - Example: LATENCY=4, accepted at edge N -> mem_ready high during cycle N+4.
REQ-030 Address, data, and op changes on the inputs after acceptance SHALL NOT affect the in-flight response.

Reset
REQ-031 While rst_n is low, SHALL force state=IDLE, mem_ready=0, mem_hit=0, mem_data_in=0, busy=0, counter=0.
REQ-032 Reset mid-operation SHALL abort the request with no response; a pending write SHALL NOT be committed.
REQ-033 SHALL leave array contents unchanged by reset; contents are undefined at power-up unless preloaded by the bench.

Structure
REQ-034 SHALL place in shared package mem_pkg:
  - state enum/encoding;
  - LATENCY_MIN/LATENCY_MAX constants;
  - index-width helper localparams.
REQ-035 SHALL instantiate one sub-module, mem_array: single-port synchronous RAM, MEM_DEPTH x DATA_WIDTH, with write enable and asynchronous read.
REQ-036 SHALL size the counter as 4 bits.

Verification
REQ-037 Read hit: preload word 5 = 0xDEADBEEF; mem_read=1, mem_addr=0x14 at cycle 0 -> mem_ready=1, mem_hit=1, mem_data_in=0xDEADBEEF at cycle 4 only.
REQ-038 Write then read: write 0x12345678 to 0x40 -> ready at +4; then read 0x40 -> 0x12345678 with mem_hit=1.
REQ-039 Out-of-range: read 0x0000_1000 with MEM_DEPTH=1024 -> mem_ready=1, mem_hit=0, mem_data_in=0; a write to the same address leaves all words unchanged.
REQ-040 Held request: mem_read held high for 10 cycles -> exactly one mem_ready pulse; a second acceptance occurs no earlier than cycle 6.
REQ-041 Simultaneous read and write to 0x8 with data 0xA5A5A5A5 -> treated as a write; a subsequent read of 0x8 returns 0xA5A5A5A5.
REQ-042 Reset mid-op: assert rst_n=0 at cycle 2 of a write to 0x10 -> no mem_ready; word 4 keeps its old value; busy=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder: FSM states, latency limits
// and helpers that derive address-slicing widths from the memory geometry.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESP    = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned CNT_WIDTH   = 4;

    // Number of byte-offset bits below the word index.
    function automatic int unsigned byte_off_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned word_idx_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Backing store: single-port RAM with synchronous write and asynchronous read.
// No reset, so contents survive a responder reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            i_we,
    input  logic [word_idx_bits(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]                i_wdata,
    output logic [WIDTH-1:0]                o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory model answering cache read/write requests,
// with a one-cycle holdoff after each response to absorb held request levels.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_ready,
    output logic                  mem_hit,
    output logic                  busy
);

    localparam int unsigned OFF_BITS = byte_off_bits(DATA_WIDTH);
    localparam int unsigned IDX_BITS = word_idx_bits(MEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic [CNT_WIDTH-1:0]    w_cnt_dec;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_is_write;
    logic [DATA_WIDTH-1:0]   r_rdata_hold;
    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_we;
    logic [IDX_BITS-1:0]     w_idx;
    logic [DATA_WIDTH-1:0]   w_arr_rdata;
    logic [DATA_WIDTH-1:0]   w_resp_data;

    assign w_accept   = (r_state == IDLE) && (mem_read || mem_write);
    assign w_cnt_dec  = r_cnt - 1'b1;
    assign w_in_range = ((r_addr >> (OFF_BITS + IDX_BITS)) == '0);
    assign w_idx      = r_addr[OFF_BITS +: IDX_BITS];
    assign w_we       = (r_state == RESP) && r_is_write && w_in_range;

    // WAIT leaves on the edge where the counter reaches zero, so RESP is
    // reached exactly LATENCY cycles after the accepting edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_dec == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = HOLDOFF;
            end
            HOLDOFF: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr     <= mem_addr;
                r_wdata    <= mem_data_out;
                r_is_write <= mem_write;
            end
            if (r_state == RESP) begin
                r_rdata_hold <= w_resp_data;
            end
        end
    end

    mem_array #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign w_resp_data = (!r_is_write && w_in_range) ? w_arr_rdata : '0;

    assign mem_ready   = (r_state == RESP);
    assign mem_hit     = mem_ready && w_in_range;
    assign mem_data_in = mem_ready ? w_resp_data : r_rdata_hold;
    assign busy        = (r_state != IDLE);

endmodule
